// File: rtl/commit_arbiter.sv
// Commit-bus arbiter: one registered grant per unstalled cycle, round-robin by default.
// Define COMMIT_ARB_FIXED_PRIORITY_EN for lowest-index-wins arbitration (no pointer).
module commit_arbiter #(
  parameter int NUM_STATIONS = 4,
  parameter int PACKET_W     = 100
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [NUM_STATIONS-1:0]          iCommitRequest,
  input  logic [NUM_STATIONS*PACKET_W-1:0] iCommitData,
  input  logic                             iStall,
  output logic [NUM_STATIONS-1:0]          oCommitGranted,
  output logic                             oCommitValid,
  output logic [PACKET_W-1:0]              oCommitBus,
  output logic [3:0]                       oCommitSrc,
  output logic                             oBusy
);

  logic [NUM_STATIONS-1:0] r_mask;
  logic [NUM_STATIONS-1:0] r_granted;
  logic                    r_valid;
  logic [PACKET_W-1:0]     r_bus;
  logic [3:0]              r_src;

  logic [NUM_STATIONS-1:0] w_eligible;
  logic [NUM_STATIONS-1:0] w_grant;
  logic                    w_found;
  logic [3:0]              w_win;
  logic [PACKET_W-1:0]     w_packet;

  // Last winner sits out one decision while its request is still falling.
  assign w_eligible = iCommitRequest & ~r_mask;

`ifdef COMMIT_ARB_FIXED_PRIORITY_EN
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_STATIONS - 1; k >= 0; k--) begin
      if (w_eligible[k]) begin
        w_found = 1'b1;
        w_win   = 4'(k);
      end
    end
  end
`else
  logic [3:0] r_ptr;

  // Descending scans with last-write-wins: stations at/after the pointer override wrapped ones.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NUM_STATIONS - 1; k >= 0; k--) begin
      if (w_eligible[k] && (k < int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = 4'(k);
      end
    end
    for (int k = NUM_STATIONS - 1; k >= 0; k--) begin
      if (w_eligible[k] && (k >= int'(r_ptr))) begin
        w_found = 1'b1;
        w_win   = 4'(k);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (!iStall && w_found) begin
      r_ptr <= (w_win == 4'(NUM_STATIONS - 1)) ? 4'd0 : w_win + 4'd1;
    end
  end
`endif

  always_comb begin
    w_grant  = '0;
    w_packet = '0;
    for (int k = 0; k < NUM_STATIONS; k++) begin
      if (w_found && (w_win == 4'(k))) begin
        w_grant[k] = 1'b1;
        w_packet   = iCommitData[k*PACKET_W +: PACKET_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mask    <= '0;
      r_granted <= '0;
      r_valid   <= 1'b0;
      r_bus     <= '0;
      r_src     <= '0;
    end else if (iStall) begin
      r_granted <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_mask    <= w_grant;
      r_granted <= w_grant;
      r_valid   <= w_found;
      if (w_found) begin
        r_bus <= w_packet;
        r_src <= w_win;
      end
    end
  end

  assign oCommitGranted = r_granted;
  assign oCommitValid   = r_valid;
  assign oCommitBus     = r_bus;
  assign oCommitSrc     = r_src;
  assign oBusy          = i_rst_n & ((|w_eligible) | r_valid);

endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter (round-robin build): hand-computed grant/bus/src/busy expectations.
module tb_commit_arbiter;
  localparam int N  = 4;
  localparam int PW = 100;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*PW-1:0] data = '0;
  logic            stall = 1'b0;
  logic [N-1:0]    gnt;
  logic            valid;
  logic [PW-1:0]   bus;
  logic [3:0]      src;
  logic            busy;

  int n_checks = 0;
  int n_errors = 0;

  commit_arbiter #(.NUM_STATIONS(N), .PACKET_W(PW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .iCommitRequest (req),
    .iCommitData    (data),
    .iStall         (stall),
    .oCommitGranted (gnt),
    .oCommitValid   (valid),
    .oCommitBus     (bus),
    .oCommitSrc     (src),
    .oBusy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [N-1:0] e_gnt, input logic e_valid,
                           input logic [3:0] e_src, input logic [PW-1:0] e_bus);
    $display("txn %s: gnt=%b valid=%b src=%0d bus=%0h busy=%b", tag, gnt, valid, src, bus, busy);
    check_val({tag, ".gnt"},   128'(gnt),   128'(e_gnt));
    check_val({tag, ".valid"}, 128'(valid), 128'(e_valid));
    check_val({tag, ".src"},   128'(src),   128'(e_src));
    check_val({tag, ".bus"},   128'(bus),   128'(e_bus));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int k, input logic [PW-1:0] v);
    data[k*PW +: PW] = v;
  endtask

  localparam logic [PW-1:0] PK_ABC = 100'hC000000000000000000000ABC;
  localparam logic [PW-1:0] PK_0   = 100'h8000000000000000000000111;
  localparam logic [PW-1:0] PK_3   = 100'h4000000000000000000000333;
  localparam logic [PW-1:0] PK_1   = 100'h200000000000000000000001A;
  localparam logic [PW-1:0] PK_2   = 100'h100000000000000000000002A;

  logic [N-1:0] rr_req [6];
  int           rr_win [6];

  initial begin
    rr_req[0] = 4'b1111; rr_win[0] = 0;
    rr_req[1] = 4'b1111; rr_win[1] = 1;
    rr_req[2] = 4'b1110; rr_win[2] = 2;
    rr_req[3] = 4'b1101; rr_win[3] = 3;
    rr_req[4] = 4'b1011; rr_win[4] = 0;
    rr_req[5] = 4'b0111; rr_win[5] = 1;

    // Reset state
    repeat (2) tick();
    check_out("reset", 4'b0000, 1'b0, 4'd0, '0);
    check_val("reset.busy", 128'(busy), 128'(0));
    rst_n = 1'b1;

    // Single request on station 2, held one cycle past its grant
    set_pkt(2, PK_ABC);
    req = 4'b0100;
    tick();
    check_out("single", 4'b0100, 1'b1, 4'd2, PK_ABC);
    check_val("single.busy", 128'(busy), 128'(1));
    tick();
    check_out("single_mask", 4'b0000, 1'b0, 4'd2, PK_ABC);
    req = '0;
    tick();

    // Wrap: pointer now 3, stations 0 and 3 request
    set_pkt(0, PK_0);
    set_pkt(3, PK_3);
    req = 4'b1001;
    tick();
    check_out("wrap_s3", 4'b1000, 1'b1, 4'd3, PK_3);
    req = 4'b0001;
    tick();
    check_out("wrap_s0", 4'b0001, 1'b1, 4'd0, PK_0);
    req = '0;
    tick();
    check_out("idle_hold", 4'b0000, 1'b0, 4'd0, PK_0);
    check_val("idle.busy", 128'(busy), 128'(0));

    // Stall for three cycles with stations 1 and 2 requesting, pointer at 1
    set_pkt(1, PK_1);
    set_pkt(2, PK_2);
    req   = 4'b0110;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("stall", 4'b0000, 1'b0, 4'd0, PK_0);
      check_val("stall.busy", 128'(busy), 128'(1));
    end
    stall = 1'b0;
    tick();
    check_out("post_stall_s1", 4'b0010, 1'b1, 4'd1, PK_1);
    tick();
    check_out("post_stall_s2", 4'b0100, 1'b1, 4'd2, PK_2);
    req = '0;
    tick();
    check_out("post_stall_idle", 4'b0000, 1'b0, 4'd2, PK_2);

    // Request dropped while stalled is simply lost
    req   = 4'b0001;
    stall = 1'b1;
    tick();
    stall = 1'b0;
    req   = '0;
    tick();
    check_out("dropped", 4'b0000, 1'b0, 4'd2, PK_2);

    // Asynchronous reset in the decision cycle of a grant to station 1
    req = 4'b0001;
    tick();
    check_out("pre_reset", 4'b0001, 1'b1, 4'd0, PK_0);
    req = 4'b0010;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 4'b0000, 1'b0, 4'd0, '0);
    check_val("async_reset.busy", 128'(busy), 128'(0));
    tick();
    check_out("reset_held", 4'b0000, 1'b0, 4'd0, '0);
    rst_n = 1'b1;
    req   = 4'b1001;
    tick();
    check_out("resume", 4'b0001, 1'b1, 4'd0, PK_0);

    // Round-robin with all stations re-requesting, starting from a fresh reset
    req   = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < N; k++) set_pkt(k, PW'(128'hD0 + 128'(k)));
    for (int t = 0; t < 6; t++) begin
      req = rr_req[t];
      tick();
      check_out($sformatf("rr%0d", t), 4'(1 << rr_win[t]), 1'b1, 4'(rr_win[t]),
                PW'(128'hD0 + 128'(rr_win[t])));
    end
    req = '0;
    tick();
    tick();
    check_out("final_idle", 4'b0000, 1'b0, 4'd1, PW'(128'hD1));
    check_val("final.busy", 128'(busy), 128'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
